// File: rtl/spu32_cpu_alu_arbiter_pkg.sv
// spu32_cpu_alu_arbiter_pkg: ALU opcodes, arbiter state encodings and shift-op helper
package spu32_cpu_alu_arbiter_pkg;
  localparam logic [3:0] ALUOP_ADD  = 4'd0;
  localparam logic [3:0] ALUOP_SUB  = 4'd1;
  localparam logic [3:0] ALUOP_AND  = 4'd2;
  localparam logic [3:0] ALUOP_OR   = 4'd3;
  localparam logic [3:0] ALUOP_XOR  = 4'd4;
  localparam logic [3:0] ALUOP_SLT  = 4'd5;
  localparam logic [3:0] ALUOP_SLTU = 4'd6;
  localparam logic [3:0] ALUOP_SLL  = 4'd7;
  localparam logic [3:0] ALUOP_SRL  = 4'd8;
  localparam logic [3:0] ALUOP_SRA  = 4'd9;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_SHIFT = 2'd2} arb_state_e;
  function automatic logic is_shift(input logic [3:0] op);
    return op == ALUOP_SLL || op == ALUOP_SRL || op == ALUOP_SRA;
  endfunction
endpackage

// File: rtl/spu32_cpu_alu_arbiter.sv
// spu32_cpu_alu_arbiter: round-robin share of one ALU by two requesters (req/ready in, resp pulse + held data/flags out, O_alu_* / I_alu_* to the ALU)
module spu32_cpu_alu_arbiter
  import spu32_cpu_alu_arbiter_pkg::*;
#(
  parameter bit SINGLE_CYCLE_SHIFT = 1'b0
) (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic        I_req0_valid,
  input  logic [3:0]  I_req0_aluop,
  input  logic [31:0] I_req0_s1,
  input  logic [31:0] I_req0_s2,
  output logic        O_req0_ready,
  input  logic        I_req1_valid,
  input  logic [3:0]  I_req1_aluop,
  input  logic [31:0] I_req1_s1,
  input  logic [31:0] I_req1_s2,
  output logic        O_req1_ready,
  output logic        O_resp0_valid,
  output logic        O_resp1_valid,
  output logic [31:0] O_resp_data,
  output logic        O_resp_lt,
  output logic        O_resp_ltu,
  output logic        O_resp_eq,
  output logic        O_alu_en,
  output logic [3:0]  O_alu_op,
  output logic [31:0] O_alu_s1,
  output logic [31:0] O_alu_s2,
  input  logic        I_alu_busy,
  input  logic [31:0] I_alu_data,
  input  logic        I_alu_lt,
  input  logic        I_alu_ltu,
  input  logic        I_alu_eq
);
  arb_state_e  state_q, state_d;
  logic        rr_q, rr_d, id_q, id_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] s1_q, s1_d, s2_q, s2_d, data_q, data_d;
  logic        resp0_q, resp0_d, resp1_q, resp1_d;
  logic        lt_q, lt_d, ltu_q, ltu_d, eq_q, eq_d;
  logic        grant0, grant1, capture;
  assign grant0        = I_req0_valid && (!I_req1_valid || !rr_q);
  assign grant1        = I_req1_valid && (!I_req0_valid || rr_q);
  assign O_req0_ready  = state_q == ST_IDLE && grant0;
  assign O_req1_ready  = state_q == ST_IDLE && grant1;
  assign O_alu_op      = op_q;
  assign O_alu_s1      = s1_q;
  assign O_alu_s2      = s2_q;
  assign O_resp0_valid = resp0_q;
  assign O_resp1_valid = resp1_q;
  assign O_resp_data   = data_q;
  assign O_resp_lt     = lt_q;
  assign O_resp_ltu    = ltu_q;
  assign O_resp_eq     = eq_q;
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    id_d     = id_q;
    op_d     = op_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    O_alu_en = 1'b0;
    capture  = 1'b0;
    case (state_q)
      ST_IDLE: if (grant0 || grant1) begin
        state_d = ST_ISSUE;
        rr_d    = grant0;
        id_d    = grant1;
        op_d    = grant1 ? I_req1_aluop : I_req0_aluop;
        s1_d    = grant1 ? I_req1_s1 : I_req0_s1;
        s2_d    = grant1 ? I_req1_s2 : I_req0_s2;
      end
      ST_ISSUE: begin
        O_alu_en = 1'b1;
        state_d  = is_shift(op_q) && !SINGLE_CYCLE_SHIFT ? ST_SHIFT : ST_IDLE;
        capture  = state_d == ST_IDLE;
      end
      // en must fall with busy, otherwise the ALU would start the shift again
      ST_SHIFT: begin
        O_alu_en = I_alu_busy;
        capture  = !I_alu_busy;
        state_d  = I_alu_busy ? ST_SHIFT : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    resp0_d = capture && !id_q;
    resp1_d = capture && id_q;
    data_d  = capture ? I_alu_data : data_q;
    lt_d    = capture ? I_alu_lt : lt_q;
    ltu_d   = capture ? I_alu_ltu : ltu_q;
    eq_d    = capture ? I_alu_eq : eq_q;
  end
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state_q <= ST_IDLE;
      rr_q    <= 1'b0;
      id_q    <= 1'b0;
      op_q    <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      resp0_q <= 1'b0;
      resp1_q <= 1'b0;
      data_q  <= '0;
      lt_q    <= 1'b0;
      ltu_q   <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      op_q    <= op_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      resp0_q <= resp0_d;
      resp1_q <= resp1_d;
      data_q  <= data_d;
      lt_q    <= lt_d;
      ltu_q   <= ltu_d;
      eq_q    <= eq_d;
    end
  end
endmodule

// File: tb/tb_spu32_cpu_alu_arbiter.sv
// tb_spu32_cpu_alu_arbiter: ALU model + transaction-level arbiter model with per-cycle compare and directed vectors
module tb_spu32_cpu_alu_arbiter;
  import spu32_cpu_alu_arbiter_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic v0 = 0, v1 = 0;
  logic [3:0] op0 = 0, op1 = 0;
  logic [31:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic rdy0, rdy1, rsp0, rsp1, rlt, rltu, req, alu_en, alu_busy;
  logic [31:0] rdata, alu_s1, alu_s2, alu_data;
  logic [3:0] alu_op;
  logic bv = 0;
  logic [3:0] bop = 0;
  logic [31:0] bs1 = 0, bs2 = 0;
  logic b_rdy, b_rdy1, b_rsp0, b_rsp1, b_lt, b_ltu, b_eq, b_en;
  logic [31:0] b_data, b_s1, b_s2;
  logic [3:0] b_op;
  int passed = 0, total = 0, cyc = 0;
  int cnt = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALUOP_SUB:  return a - b;
      ALUOP_AND:  return a & b;
      ALUOP_OR:   return a | b;
      ALUOP_XOR:  return a ^ b;
      ALUOP_SLT:  return {31'b0, $signed(a) < $signed(b)};
      ALUOP_SLTU: return {31'b0, a < b};
      ALUOP_SLL:  return a << b[4:0];
      ALUOP_SRL:  return a >> b[4:0];
      ALUOP_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      default:    return a + b;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  // ALU stand-in: result and flags follow the operands; a multi-cycle shift keeps busy high for s2[4:0] cycles after the enabling edge
  assign alu_busy = cnt != 0;
  assign alu_data = alu_f(alu_op, alu_s1, alu_s2);
  always @(posedge clk) begin
    if (rst) cnt <= 0;
    else if (cnt != 0) cnt <= cnt - 1;
    else if (alu_en && alu_op inside {ALUOP_SLL, ALUOP_SRL, ALUOP_SRA}) cnt <= int'(alu_s2[4:0]);
  end

  spu32_cpu_alu_arbiter #(.SINGLE_CYCLE_SHIFT(1'b0)) dut (
    .I_clk(clk), .I_reset(rst),
    .I_req0_valid(v0), .I_req0_aluop(op0), .I_req0_s1(a0), .I_req0_s2(b0), .O_req0_ready(rdy0),
    .I_req1_valid(v1), .I_req1_aluop(op1), .I_req1_s1(a1), .I_req1_s2(b1), .O_req1_ready(rdy1),
    .O_resp0_valid(rsp0), .O_resp1_valid(rsp1), .O_resp_data(rdata),
    .O_resp_lt(rlt), .O_resp_ltu(rltu), .O_resp_eq(req),
    .O_alu_en(alu_en), .O_alu_op(alu_op), .O_alu_s1(alu_s1), .O_alu_s2(alu_s2),
    .I_alu_busy(alu_busy), .I_alu_data(alu_data),
    .I_alu_lt($signed(alu_s1) < $signed(alu_s2)), .I_alu_ltu(alu_s1 < alu_s2), .I_alu_eq(alu_s1 == alu_s2)
  );

  spu32_cpu_alu_arbiter #(.SINGLE_CYCLE_SHIFT(1'b1)) dut_b (
    .I_clk(clk), .I_reset(rst),
    .I_req0_valid(bv), .I_req0_aluop(bop), .I_req0_s1(bs1), .I_req0_s2(bs2), .O_req0_ready(b_rdy),
    .I_req1_valid(1'b0), .I_req1_aluop(4'd0), .I_req1_s1(32'd0), .I_req1_s2(32'd0), .O_req1_ready(b_rdy1),
    .O_resp0_valid(b_rsp0), .O_resp1_valid(b_rsp1), .O_resp_data(b_data),
    .O_resp_lt(b_lt), .O_resp_ltu(b_ltu), .O_resp_eq(b_eq),
    .O_alu_en(b_en), .O_alu_op(b_op), .O_alu_s1(b_s1), .O_alu_s2(b_s2),
    .I_alu_busy(1'b0), .I_alu_data(alu_f(b_op, b_s1, b_s2)),
    .I_alu_lt($signed(b_s1) < $signed(b_s2)), .I_alu_ltu(b_s1 < b_s2), .I_alu_eq(b_s1 == b_s2)
  );

  // Transaction model: an accepted op owns the ALU until its response cycle; responses are scheduled by latency
  int free_at = 0, en_from = 0, en_to = -1, due = 0, n = 0;
  bit pend = 0, pend_id = 0, rr = 0, ev, g0, g1, sh;
  logic [31:0] m_data = 0, m_s1 = 0, m_s2 = 0, p_data = 0;
  logic [3:0] m_op = 0;
  logic m_lt = 0, m_ltu = 0, m_eq = 0, p_lt = 0, p_ltu = 0, p_eq = 0;
  always @(negedge clk) begin
    if (rst) begin
      free_at = cyc + 1; en_from = 0; en_to = -1; pend = 0; rr = 0;
      m_data = 0; m_lt = 0; m_ltu = 0; m_eq = 0; m_op = 0; m_s1 = 0; m_s2 = 0;
    end else begin
      ev = pend && due == cyc;
      if (ev) begin
        m_data = p_data; m_lt = p_lt; m_ltu = p_ltu; m_eq = p_eq; pend = 0;
      end
      chk("resp0_valid", rsp0, ev && !pend_id);
      chk("resp1_valid", rsp1, ev && pend_id);
      chk("resp_data", rdata, m_data);
      chk("resp_flags", {rlt, rltu, req}, {m_lt, m_ltu, m_eq});
      g0 = cyc >= free_at && v0 && (!v1 || !rr);
      g1 = cyc >= free_at && v1 && (!v0 || rr);
      chk("ready0", rdy0, g0);
      chk("ready1", rdy1, g1);
      chk("alu_en", alu_en, cyc >= en_from && cyc <= en_to);
      chk("alu_op", alu_op, m_op);
      chk("alu_s1", alu_s1, m_s1);
      chk("alu_s2", alu_s2, m_s2);
      if (g0 || g1) begin
        pend_id = g1;
        m_op = g1 ? op1 : op0;
        m_s1 = g1 ? a1 : a0;
        m_s2 = g1 ? b1 : b0;
        sh = m_op inside {ALUOP_SLL, ALUOP_SRL, ALUOP_SRA};
        n = sh ? int'(m_s2[4:0]) : 0;
        en_from = cyc + 1;
        en_to = cyc + 1 + n;
        due = sh ? cyc + 3 + n : cyc + 2;
        free_at = due;
        p_data = alu_f(m_op, m_s1, m_s2);
        p_lt = $signed(m_s1) < $signed(m_s2);
        p_ltu = m_s1 < m_s2;
        p_eq = m_s1 == m_s2;
        pend = 1;
        rr = g0;
      end
    end
  end

  task automatic run_op(input bit r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lag, input string nm);
    int k, c0;
    @(posedge clk); #1;
    if (r) begin v1 = 1; op1 = op; a1 = a; b1 = b; end
    else begin v0 = 1; op0 = op; a0 = a; b0 = b; end
    k = 0;
    @(negedge clk);
    while (!(r ? rdy1 : rdy0) && k < 20) begin @(negedge clk); k++; end
    c0 = cyc;
    chk({nm, " ready"}, r ? rdy1 : rdy0, 1);
    @(posedge clk); #1;
    v0 = 0; v1 = 0;
    k = 0;
    @(negedge clk);
    while (!(r ? rsp1 : rsp0) && k < 60) begin @(negedge clk); k++; end
    chk({nm, " lag"}, cyc - c0, lag);
    chk({nm, " data"}, rdata, exp);
    chk({nm, " other valid"}, r ? rsp0 : rsp1, 0);
  endtask

  initial begin
    int k, c0, pulses;
    bit g;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset alu_en", alu_en, 0);
    chk("reset alu_op/s1/s2", {28'd0, alu_op} | alu_s1 | alu_s2, 0);
    chk("reset resp_data", rdata, 0);
    chk("reset resp valids", {rsp0, rsp1}, 0);
    run_op(0, ALUOP_ADD, 5, 7, 12, 2, "add 5+7");
    run_op(1, ALUOP_SLTU, 1, 32'hFFFF_FFFF, 1, 2, "sltu");
    chk("sltu flags lt/ltu/eq", {rlt, rltu, req}, 3'b010);
    run_op(1, ALUOP_SUB, 3, 3, 0, 2, "sub 3-3");
    chk("sub eq", req, 1);
    run_op(0, ALUOP_SRA, 32'h8000_0000, 4, 32'hF800_0000, 7, "sra by 4");
    run_op(0, ALUOP_SLL, 32'h0000_ABCD, 0, 32'h0000_ABCD, 3, "sll by 0");
    run_op(0, 4'hF, 2, 3, 5, 2, "unused op as add");
    // round robin from a fresh reset with both requesters always pending
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    v0 = 1; op0 = ALUOP_ADD; a0 = 10; b0 = 20;
    v1 = 1; op1 = ALUOP_XOR; a1 = 32'hFF00; b1 = 32'h0F0F;
    for (int i = 0; i < 4; i++) begin
      k = 0;
      @(negedge clk);
      while (!rdy0 && !rdy1 && k < 20) begin @(negedge clk); k++; end
      g = rdy1;
      chk($sformatf("rr grant %0d", i), {rdy1, rdy0}, (i % 2) ? 2'b10 : 2'b01);
      @(posedge clk); #1;
      if (i == 3) begin v0 = 0; v1 = 0; end
      else if (g) a1 = a1 + 32'h11;
      else a0 = a0 + 3;
    end
    repeat (4) @(negedge clk);
    // reset in the middle of a long shift discards the response
    @(posedge clk); #1 v0 = 1; op0 = ALUOP_SRL; a0 = 32'hF000_0000; b0 = 20;
    k = 0;
    @(negedge clk);
    while (!rdy0 && k < 20) begin @(negedge clk); k++; end
    chk("srl accept", rdy0, 1);
    @(posedge clk); #1 v0 = 0;
    repeat (5) @(negedge clk);
    chk("srl busy before reset", alu_busy, 1);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    pulses = 0;
    repeat (25) begin @(negedge clk); pulses += int'(rsp0) + int'(rsp1); end
    chk("no pulse after reset", pulses, 0);
    chk("alu busy cleared", alu_busy, 0);
    run_op(0, ALUOP_ADD, 32'hFFFF_FFFF, 2, 1, 2, "add after reset");
    // single-cycle shifter variant
    @(posedge clk); #1 bv = 1; bop = ALUOP_SLL; bs1 = 1; bs2 = 31;
    k = 0;
    @(negedge clk);
    while (!b_rdy && k < 20) begin @(negedge clk); k++; end
    c0 = cyc;
    chk("scs accept", b_rdy, 1);
    @(posedge clk); #1 bv = 0;
    k = 0;
    @(negedge clk);
    chk("scs alu_en", b_en, 1);
    while (!b_rsp0 && k < 20) begin @(negedge clk); k++; end
    chk("scs lag", cyc - c0, 2);
    chk("scs data", b_data, 32'h8000_0000);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
